// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// Transmit datapath and control for the UART. This block sits directly
// downstream of bit_time_counter.
//
// When load is strobed while the engine is idle, it latches one byte and
// builds an 11-bit-time frame. It then shifts the frame out LSB first, one
// bit per btu pulse. While a frame is in flight, do_it is high. That signal
// enables the bit_time_counter, whose select is {do_it, btu}.
//
// Every frame is 11 bit times long: a start bit, 7 or 8 data bits, an
// optional parity bit, and stop bits that pad out the rest of the frame.
//
// Ports
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset (aborts any frame)
//   load      in   1  one-cycle write strobe, honoured only while tx_rdy=1
//   out_port  in   8  data byte, sampled in the load cycle
//   eight     in   1  1 = 8 data bits, 0 = 7 data bits (out_port[6:0])
//   pen       in   1  parity enable
//   ohel      in   1  parity sense: 0 = even, 1 = odd
//   btu       in   1  bit-time-up pulse from bit_time_counter
//   do_it     out  1  frame in progress (bit_time_counter sel[1])
//   tx        out  1  serial line, idle high, registered
//   tx_rdy    out  1  idle and able to accept a load
// -----------------------------------------------------------------------------
module uart_tx_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] out_port,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       btu,
  output logic       do_it,
  output logic       tx,
  output logic       tx_rdy
);

  localparam logic [3:0] FRAME_BITS = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e      state_q;
  logic [10:0] shift_q;
  logic [3:0]  bit_cnt_q;
  logic        do_it_q;
  logic        tx_rdy_q;

  logic        parity_d;
  logic [10:0] frame_d;
  logic        done;

  // The parity bit is taken from the live inputs. It only matters in the
  // cycle where load is accepted, because that is the only time the frame
  // is captured.
  always_comb begin
    parity_d = (eight ? ^out_port[7:0] : ^out_port[6:0]) ^ ohel;
  end

  // Build the frame. Bit 0 is the start bit. Any position that is not used
  // by data or parity becomes an extra stop bit.
  always_comb begin
    frame_d = 11'h7FF;
    unique case ({eight, pen})
      2'b11: frame_d = {1'b1, parity_d, out_port[7:0], 1'b0};
      2'b10: frame_d = {2'b11, out_port[7:0], 1'b0};
      2'b01: frame_d = {2'b11, parity_d, out_port[6:0], 1'b0};
      2'b00: frame_d = {3'b111, out_port[6:0], 1'b0};
      default: frame_d = 11'h7FF;
    endcase
  end

  assign done = (bit_cnt_q == FRAME_BITS);

  // NOTE: every register in this block is assigned with <=. That way each
  // right-hand side reads the value from before the edge, whatever order
  // the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 11'h7FF;
      bit_cnt_q <= 4'd0;
      do_it_q   <= 1'b0;
      tx_rdy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // While idle, btu is ignored. A btu that arrives in the same cycle
          // as the load is also dropped, so the first shift waits for the
          // next btu.
          if (load) begin
            state_q   <= SEND;
            shift_q   <= frame_d;
            bit_cnt_q <= 4'd0;
            do_it_q   <= 1'b1;
            tx_rdy_q  <= 1'b0;
          end
        end
        SEND: begin
          // done takes priority over btu. This stops bit_cnt at 11, and any
          // btu that lands in the done cycle is dropped. By this point the
          // shifter has already filled with ones, so tx stays high.
          if (done) begin
            state_q  <= IDLE;
            do_it_q  <= 1'b0;
            tx_rdy_q <= 1'b1;
          end else if (btu) begin
            shift_q   <= {1'b1, shift_q[10:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          shift_q   <= 11'h7FF;
          bit_cnt_q <= 4'd0;
          do_it_q   <= 1'b0;
          tx_rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx     = shift_q[0];
  assign do_it  = do_it_q;
  assign tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
//
// Directed bench for uart_tx_engine.
//
// Most frames come from a table. Each table entry holds the inputs, the
// expected 11-bit line sequence (LSB first) and a few corner-case knobs:
//   - the btu spacing between bits,
//   - a btu arriving in the load cycle,
//   - a stray load during the frame,
//   - load/btu poked in the done cycle.
//
// Hand-written sequences cover the idle behaviour after reset and a reset
// that aborts a frame. A final sequence drives btu from a model of
// bit_time_counter with baud_count = 108.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] out_port;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       btu;
  logic       do_it;
  logic       tx;
  logic       tx_rdy;

  logic       btu_man;
  logic       use_ctr;
  logic [3:0] ctr;
  logic       ctr_btu;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  uart_tx_engine dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .btu      (btu),
    .do_it    (do_it),
    .tx       (tx),
    .tx_rdy   (tx_rdy)
  );

  // Model of bit_time_counter with baud_count = 108 (4'b1011).
  //   {do_it, btu} = 0x : counter is held at 0
  //   {do_it, btu} = 10 : counter increments
  //   {do_it, btu} = 11 : counter is cleared
  logic [7:0] baud_ctr;
  assign ctr_btu = (baud_ctr == 8'd108);
  always @(posedge clk) begin
    if (rst || !do_it || ctr_btu) baud_ctr <= 8'd0;
    else                          baud_ctr <= baud_ctr + 8'd1;
  end
  assign ctr = 4'b1011;

  assign btu = use_ctr ? ctr_btu : btu_man;

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    int          gap;          // clocks per bit, btu on the last one
    logic        btu_on_load;  // btu asserted in the load cycle
    int          mid_load_at;  // bit index for a stray load of 0xFF, -1 none
    logic        done_poke;    // load + btu in the done cycle
    logic [10:0] exp;          // expected line bits, bit 0 first
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int id, input vec_t v);
    out_port = v.data;
    eight    = v.eight;
    pen      = v.pen;
    ohel     = v.ohel;
    load     = 1'b1;
    btu_man  = v.btu_on_load;
    step();
    load     = 1'b0;
    btu_man  = 1'b0;

    // Scramble the inputs after the load. The frame in flight must not change.
    out_port = ~v.data;
    eight    = ~v.eight;
    pen      = ~v.pen;
    ohel     = ~v.ohel;
    check1($sformatf("v%0d start do_it", id), do_it, 1'b1);
    check1($sformatf("v%0d start tx_rdy", id), tx_rdy, 1'b0);

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < v.gap - 1; k++) begin
        if (i == v.mid_load_at && k == 0) begin
          load     = 1'b1;
          out_port = 8'hFF;
        end
        step();
        load = 1'b0;
      end
      check1($sformatf("v%0d tx bit%0d", id, i), tx, v.exp[i]);
      check1($sformatf("v%0d do_it bit%0d", id, i), do_it, 1'b1);
      btu_man = 1'b1;
      step();
      btu_man = 1'b0;
    end

    // Done cycle: the last btu has been taken and tx_rdy is not yet back.
    check1($sformatf("v%0d done tx", id), tx, 1'b1);
    check1($sformatf("v%0d done do_it", id), do_it, 1'b1);
    check1($sformatf("v%0d done tx_rdy", id), tx_rdy, 1'b0);
    if (v.done_poke) begin
      load     = 1'b1;
      btu_man  = 1'b1;
      out_port = 8'h00;
    end
    step();
    load    = 1'b0;
    btu_man = 1'b0;
    check1($sformatf("v%0d end tx_rdy", id), tx_rdy, 1'b1);
    check1($sformatf("v%0d end do_it", id), do_it, 1'b0);
    check1($sformatf("v%0d end tx", id), tx, 1'b1);

    // One more idle cycle. No second frame may have started.
    step();
    check1($sformatf("v%0d idle tx_rdy", id), tx_rdy, 1'b1);
    check1($sformatf("v%0d idle tx", id), tx, 1'b1);
  endtask

  initial begin
    vec_t v_after_rst;
    int   bad[11];
    int   done_bad;
    logic [10:0] exp6;

    //            data   8     pen   odd   gap btuL  mid done  expected line
    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 4, 1'b0, -1, 1'b0, 11'b10010101010};
    vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1, 1'b1, 11'b11110000010};
    vecs[2] = '{8'hA3, 1'b1, 1'b0, 1'b0, 4, 1'b0,  3, 1'b0, 11'b11101000110};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 3, 1'b1, -1, 1'b1, 11'b10000001110};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b0, 2, 1'b0, -1, 1'b0, 11'b11100000000};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1, 1'b0, -1, 1'b1, 11'b11000000010};
    vecs[6] = '{8'h7F, 1'b0, 1'b1, 1'b0, 5, 1'b0, -1, 1'b0, 11'b11111111110};

    rst      = 1'b1;
    load     = 1'b0;
    out_port = 8'h00;
    eight    = 1'b1;
    pen      = 1'b1;
    ohel     = 1'b0;
    btu_man  = 1'b0;
    use_ctr  = 1'b0;
    step();
    step();
    check1("reset tx", tx, 1'b1);
    check1("reset tx_rdy", tx_rdy, 1'b1);
    check1("reset do_it", do_it, 1'b0);

    // After reset, idle for 20 cycles while btu toggles. Nothing may move.
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      btu_man = c[0];
      step();
      check1($sformatf("idle%0d tx", c), tx, 1'b1);
      check1($sformatf("idle%0d tx_rdy", c), tx_rdy, 1'b1);
      check1($sformatf("idle%0d do_it", c), do_it, 1'b0);
    end
    btu_man = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_frame(i, vecs[i]);

    // Load 0x00, then reset after 5 btus. Expect an immediate return to idle.
    out_port = 8'h00;
    eight    = 1'b1;
    pen      = 1'b1;
    ohel     = 1'b0;
    load     = 1'b1;
    step();
    load = 1'b0;
    for (int b = 0; b < 5; b++) begin
      step();
      step();
      step();
      btu_man = 1'b1;
      step();
      btu_man = 1'b0;
    end
    check1("abort pre tx", tx, 1'b0);
    check1("abort pre do_it", do_it, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("abort tx", tx, 1'b1);
    check1("abort tx_rdy", tx_rdy, 1'b1);
    check1("abort do_it", do_it, 1'b0);
    for (int c = 0; c < 3; c++) begin
      btu_man = 1'b1;
      step();
      btu_man = 1'b0;
      check1($sformatf("abort idle%0d tx_rdy", c), tx_rdy, 1'b1);
      check1($sformatf("abort idle%0d tx", c), tx, 1'b1);
    end
    v_after_rst = '{8'h0F, 1'b1, 1'b1, 1'b0, 4, 1'b0, -1, 1'b0, 11'b10000011110};
    run_frame(10, v_after_rst);

    // Drive btu from the counter model. Each bit must last exactly 109 clocks.
    exp6     = 11'b11110000110;  // 0xC3, 8 data bits, no parity
    use_ctr  = 1'b1;
    out_port = 8'hC3;
    eight    = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;
    load     = 1'b1;
    step();
    load     = 1'b0;
    out_port = 8'h00;
    for (int i = 0; i < 11; i++) bad[i] = 0;
    done_bad = 0;
    for (int t = 0; t <= 1199; t++) begin
      if (t < 1199) begin
        if (tx !== exp6[t / 109] || do_it !== 1'b1 || tx_rdy !== 1'b0)
          bad[t / 109]++;
      end else begin
        if (tx !== 1'b1 || do_it !== 1'b1 || tx_rdy !== 1'b0) done_bad++;
      end
      step();
    end
    for (int i = 0; i < 11; i++)
      checkn($sformatf("baud bit%0d wrong clocks", i), bad[i], 0);
    checkn("baud done cycle wrong", done_bad, 0);
    check1("baud end tx_rdy", tx_rdy, 1'b1);
    check1("baud end do_it", do_it, 1'b0);
    check1("baud end tx", tx, 1'b1);
    checkn("baud ctr setting", int'(ctr), 11);
    use_ctr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
